// File: rtl/cp0_pkg.sv
// cp0_pkg: shared CP0 constants for the M-stage exception responder and the
// fetch-redirect logic.
//   - CP0 register addresses (SR, Cause, EPC, PRId)
//   - ExcCode values
//   - bit-field positions inside SR and Cause
//   - exception entry address
package cp0_pkg;

   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;
   localparam logic [4:0] REG_PRID  = 5'd15;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   // SR fields
   localparam int unsigned IM_HI   = 15;
   localparam int unsigned IM_LO   = 10;
   localparam int unsigned EXL_BIT = 1;
   localparam int unsigned IE_BIT  = 0;

   // Cause fields
   localparam int unsigned BD_BIT  = 31;
   localparam int unsigned IP_HI   = 15;
   localparam int unsigned IP_LO   = 10;
   localparam int unsigned EXC_HI  = 6;
   localparam int unsigned EXC_LO  = 2;

   localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;

endpackage

// File: rtl/cp0_int_arb.sv
// cp0_int_arb: combinational interrupt/exception arbiter.
//   im        in  6  SR.IM interrupt mask
//   exl       in  1  SR.EXL
//   ie        in  1  SR.IE
//   hwInt     in  6  external interrupt lines
//   excCodeIn in  5  exception code of the M instruction (0 = none)
//   req       out 1  interrupt or exception request (ungated by reset)
//   excCode   out 5  ExcCode to record; interrupts win and record Int
module cp0_int_arb
   import cp0_pkg::*;
(
   input  logic [5:0] im,
   input  logic       exl,
   input  logic       ie,
   input  logic [5:0] hwInt,
   input  logic [4:0] excCodeIn,
   output logic       req,
   output logic [4:0] excCode
);

   logic intReq;
   logic excReq;

   assign intReq  = ie & ~exl & (|(hwInt & im));
   assign excReq  = ~exl & (excCodeIn != EXC_INT);
   assign req     = intReq | excReq;
   assign excCode = intReq ? EXC_INT : excCodeIn;

endmodule

// File: rtl/m_cp0.sv
// m_cp0: Coprocessor-0 exception/interrupt responder in the M stage.
//   clk       in  1   clock, rising edge
//   reset     in  1   synchronous, active-low reset
//   A1        in  5   mfc0 read address
//   A2        in  5   mtc0 write address
//   DIn       in  32  mtc0 write data
//   WE        in  1   mtc0 write enable
//   PC        in  32  PC of the M instruction
//   BDIn      in  1   M instruction is in a branch delay slot
//   ExcCodeIn in  5   exception code of the M instruction (0 = none)
//   HWInt     in  6   level-sensitive external interrupts
//   EXLClr    in  1   eret in M
//   DOut      out 32  combinational read of register A1
//   EPCOut    out 32  current EPC
//   Req       out 1   flush/redirect request
module m_cp0
   import cp0_pkg::*;
#(
   parameter logic [31:0] PRID_VALUE = 32'h2021_0701
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] DIn,
   input  logic        WE,
   input  logic [31:0] PC,
   input  logic        BDIn,
   input  logic [4:0]  ExcCodeIn,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic [31:0] DOut,
   output logic [31:0] EPCOut,
   output logic        Req
);

   logic [5:0]  im;
   logic        exl;
   logic        ie;
   logic        bd;
   logic [5:0]  ip;
   logic [4:0]  excCode;
   logic [31:0] epc;

   logic        arbReq;
   logic [4:0]  arbExcCode;
   logic [31:0] epcCapture;

   cp0_int_arb uArb (
      .im        (im),
      .exl       (exl),
      .ie        (ie),
      .hwInt     (HWInt),
      .excCodeIn (ExcCodeIn),
      .req       (arbReq),
      .excCode   (arbExcCode)
   );

   assign Req = reset & arbReq;

   // A delay-slot fault restarts at the branch; EPC is always word aligned.
   assign epcCapture = (BDIn ? PC - 32'd4 : PC) & 32'hFFFF_FFFC;

   always_ff @(posedge clk) begin
      if (!reset) begin
         im      <= '0;
         exl     <= 1'b0;
         ie      <= 1'b0;
         bd      <= 1'b0;
         ip      <= '0;
         excCode <= '0;
         epc     <= '0;
      end else begin
         ip <= HWInt;
         if (Req) begin
            // Capture wins over any mtc0 in the same cycle; EXLClr cannot be
            // meaningful here because Req implies EXL=0.
            exl     <= 1'b1;
            bd      <= BDIn;
            excCode <= arbExcCode;
            epc     <= epcCapture;
         end else begin
            if (WE && (A2 == REG_SR)) begin
               im  <= DIn[IM_HI:IM_LO];
               exl <= DIn[EXL_BIT];
               ie  <= DIn[IE_BIT];
            end
            if (WE && (A2 == REG_EPC)) begin
               epc <= DIn;
            end
            // Later assignment gives eret priority over an SR write to EXL.
            if (EXLClr) begin
               exl <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      DOut = '0;
      case (A1)
         REG_SR: begin
            DOut[IM_HI:IM_LO] = im;
            DOut[EXL_BIT]     = exl;
            DOut[IE_BIT]      = ie;
         end
         REG_CAUSE: begin
            DOut[BD_BIT]        = bd;
            DOut[IP_HI:IP_LO]   = ip;
            DOut[EXC_HI:EXC_LO] = excCode;
         end
         REG_EPC:  DOut = epc;
         REG_PRID: DOut = PRID_VALUE;
         default:  DOut = '0;
      endcase
   end

   assign EPCOut = epc;

endmodule
